reg_wb_unit: RTL and testbench
==============================

REG_WB_UNIT -- requirements
Module: reg_wb_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, rstn.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rstn  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 Port ex_we_i  input  1  EX-stage register write enable, overflow-gated upstream.
REQ-005 Port ex_waddr_i  input  5  EX-stage destination register.
REQ-006 Port ex_wdata_i  input  32  EX-stage result.
REQ-007 Port stall_i  input  1  hold MEM stage and insert a bubble into WB.
REQ-008 Port flush_i  input  1  discard the EX write and insert a bubble into MEM.
REQ-009 Port raddr1_i, raddr2_i  input  5 each  operand read addresses from ID.
REQ-010 Port rdata1_o, rdata2_o  output  32 each  forwarded operand data.
REQ-011 Port wb_we_o, wb_waddr_o, wb_wdata_o  output  1/5/32  WB-stage contents, exposed for trace.
REQ-012 Port commit_cnt_o  output  32  count of committed register-array writes.

Function
REQ-013 The block SHALL hold a 32x32 register array, a MEM-stage register {we,waddr,wdata} and a WB-stage register {we,waddr,wdata}.
REQ-014 Write path: EX is captured into MEM at edge N, moves to WB at edge N+1, and is written into the array at edge N+2.
REQ-015 Any stage entry with waddr=0 SHALL be treated as we=0, so R0 is never written and never forwarded.
REQ-016 On each edge, the array SHALL write wb_wdata to wb_waddr when wb_we=1 and wb_waddr!=0.
REQ-017 The MEM stage update SHALL follow this priority: flush_i=1 loads a bubble (we=0, addr=0, data=0); else stall_i=1 holds MEM; else MEM loads EX.
REQ-018 WB stage update: stall_i=1 and flush_i=0 loads a bubble into WB; otherwise WB loads MEM.
REQ-019 When flush_i and stall_i are both 1, the block SHALL flush MEM and move MEM into WB normally.
REQ-020 Read ports are combinational; for each port, the value SHALL be chosen by this priority: raddr=0 gives 0, then an EX match (ex_we_i=1), then a MEM match, then a WB match, then the array.
REQ-021 EX forwarding SHALL be suppressed when flush_i=1.
REQ-022 commit_cnt_o SHALL increment by 1 per array write (REQ-016) and wrap from 0xFFFFFFFF to 0.
REQ-023 wb_*_o SHALL reflect the WB-stage register directly, registered with zero combinational logic.
REQ-024 A write and a same-address read in the same cycle SHALL return the new data via the WB match, with no read-before-write hazard.

Reset
REQ-025 With rstn=0 at an edge, the block SHALL clear all 32 array entries, MEM, WB and commit_cnt_o to 0 on that edge.
REQ-026 During reset cycles, the block SHALL perform no array write, even if wb_we was 1 before reset.
REQ-027 After reset, rdata1_o and rdata2_o SHALL read 0 for every address until a write reaches a stage.
REQ-028 A reset asserted mid-pipeline SHALL discard in-flight MEM and WB entries, with no partial commit.

Verification
REQ-029 Back-to-back forwarding: EX writes R5=0x11 at cycle 0 and R5=0x22 at cycle 1, raddr1=5 -> rdata1 reads 0x11 in cycle 0 (EX), 0x22 in cycle 1 (EX beats MEM), 0x22 thereafter, and the array holds 0x22 after cycle 3.
REQ-030 R0 guard: ex_we=1, waddr=0, wdata=0xDEADBEEF -> rdata on addr 0 is always 0, and commit_cnt_o is unchanged.
REQ-031 Stall: R7=0x7 is in MEM and stall_i=1 for 2 cycles -> WB shows we=0 for 2 cycles, MEM holds R7, raddr=7 returns 0x7 throughout, and the array commits one cycle after stall drops.
REQ-032 Flush: R9=0x99 is on EX with flush_i=1 -> rdata for 9 is not 0x99 that cycle, R9 never commits, and commit_cnt_o is unchanged.
REQ-033 Reset mid-operation: R3 is in MEM and R4 is in WB, then rstn=0 for one edge -> the array, stages and counter are all 0, and neither R3 nor R4 is written.
REQ-034 Counter wrap: commit_cnt_o is preloaded to 0xFFFFFFFF via writes, then one more commit -> commit_cnt_o=0.

Source files
------------

// File: rtl/reg_wb_unit.sv
// Register file with a MEM/WB write-back pipeline, EX/MEM/WB operand forwarding,
// stall/flush bubble control and a commit counter.
module reg_wb_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] commit_cnt_o
);

  logic [31:0] r_regs [32];
  logic        r_mem_we;
  logic [4:0]  r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_wb_we;
  logic [4:0]  r_wb_waddr;
  logic [31:0] r_wb_wdata;
  logic [31:0] r_commit_cnt;

  logic w_ex_we;
  logic w_ex_fwd;
  logic w_commit;

  // A write to R0 is folded into we=0 at capture, so later stages never see it.
  assign w_ex_we  = ex_we_i && (ex_waddr_i != 5'd0);
  assign w_ex_fwd = w_ex_we && !flush_i;
  assign w_commit = r_wb_we && (r_wb_waddr != 5'd0);

  // NOTE: non-blocking assignments so MEM->WB transfer sees the pre-edge MEM value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= 5'd0;
      r_mem_wdata <= 32'd0;
      r_wb_we     <= 1'b0;
      r_wb_waddr  <= 5'd0;
      r_wb_wdata  <= 32'd0;
    end else begin
      if (flush_i) begin
        r_mem_we    <= 1'b0;
        r_mem_waddr <= 5'd0;
        r_mem_wdata <= 32'd0;
      end else if (!stall_i) begin
        r_mem_we    <= w_ex_we;
        r_mem_waddr <= ex_waddr_i;
        r_mem_wdata <= ex_wdata_i;
      end

      // Flush wins over stall for WB too: MEM still drains normally.
      if (stall_i && !flush_i) begin
        r_wb_we    <= 1'b0;
        r_wb_waddr <= 5'd0;
        r_wb_wdata <= 32'd0;
      end else begin
        r_wb_we    <= r_mem_we;
        r_wb_waddr <= r_mem_waddr;
        r_wb_wdata <= r_mem_wdata;
      end
    end
  end

  // NOTE: the array is reset entry by entry, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_commit) begin
      r_regs[r_wb_waddr] <= r_wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)         r_commit_cnt <= 32'd0;
    else if (w_commit) r_commit_cnt <= r_commit_cnt + 32'd1;
  end

  // Youngest in-flight write wins: EX, then MEM, then WB, then the array.
  function automatic logic [31:0] fwd_read(input logic [4:0] raddr);
    logic [31:0] v;
    // NOTE: v gets a value before any branch, so no path leaves it unassigned (no latch).
    v = r_regs[raddr];
    if (raddr == 5'd0)                                v = 32'd0;
    else if (w_ex_fwd && (ex_waddr_i == raddr))       v = ex_wdata_i;
    else if (r_mem_we && (r_mem_waddr == raddr))      v = r_mem_wdata;
    else if (r_wb_we && (r_wb_waddr == raddr))        v = r_wb_wdata;
    return v;
  endfunction

  always_comb begin
    rdata1_o = fwd_read(raddr1_i);
    rdata2_o = fwd_read(raddr2_i);
  end

  assign wb_we_o      = r_wb_we;
  assign wb_waddr_o   = r_wb_waddr;
  assign wb_wdata_o   = r_wb_wdata;
  assign commit_cnt_o = r_commit_cnt;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Scoreboard bench for reg_wb_unit: directed pipeline scenarios followed by
// randomized traffic, all compared against an in-flight-write reference model.
module tb_reg_wb_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        stall;
  logic        flush;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] commit_cnt;

  int n_vec = 0;
  int n_err = 0;

  reg_wb_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .ex_we_i      (ex_we),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata),
    .stall_i      (stall),
    .flush_i      (flush),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .rdata1_o     (rdata1),
    .rdata2_o     (rdata2),
    .wb_we_o      (wb_we),
    .wb_waddr_o   (wb_waddr),
    .wb_wdata_o   (wb_wdata),
    .commit_cnt_o (commit_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  logic [31:0] m_rf [32];
  wr_t         m_mem;   // oldest-but-one pending write
  wr_t         m_wb;    // oldest pending write, commits on the next edge
  logic [31:0] m_cnt;
  exp_t        exp_q [$];

  function automatic wr_t ex_entry();
    wr_t e;
    e.we = ex_we && (ex_waddr != 5'd0);
    e.a  = ex_waddr;
    e.d  = ex_wdata;
    return e;
  endfunction

  // A read sees the youngest pending write to that register, else the array.
  function automatic logic [31:0] m_read(input logic [4:0] ra);
    wr_t pend [3];
    pend[0]    = ex_entry();
    pend[0].we = pend[0].we && !flush;
    pend[1]    = m_mem;
    pend[2]    = m_wb;
    if (ra == 5'd0) return 32'd0;
    for (int k = 0; k < 3; k++)
      if (pend[k].we && pend[k].a == ra) return pend[k].d;
    return m_rf[ra];
  endfunction

  task automatic model_edge();
    wr_t nxt_mem;
    wr_t nxt_wb;
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_mem = '0;
      m_wb  = '0;
      m_cnt = 32'd0;
    end else begin
      if (m_wb.we) begin
        m_rf[m_wb.a] = m_wb.d;
        m_cnt        = m_cnt + 32'd1;
      end
      nxt_wb  = (stall && !flush) ? wr_t'('0) : m_mem;
      nxt_mem = flush ? wr_t'('0) : (stall ? m_mem : ex_entry());
      m_wb    = nxt_wb;
      m_mem   = nxt_mem;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance one edge in the model, drive the next cycle's inputs, queue expectations.
  task automatic apply(input logic rn, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic st, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rstn = rn; ex_we = we; ex_waddr = a; ex_wdata = d;
    stall = st; flush = fl; raddr1 = r1; raddr2 = r2;
    e.r1  = m_read(r1);
    e.r2  = m_read(r2);
    e.we  = m_wb.we;
    e.wa  = m_wb.a;
    e.wd  = m_wb.d;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, r1, r2);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata1",   rdata1,            e.r1);
        check("rdata2",   rdata2,            e.r2);
        check("wb_we",    32'(wb_we),        32'(e.we));
        check("wb_waddr", 32'(wb_waddr),     32'(e.wa));
        check("wb_wdata", wb_wdata,          e.wd);
        check("commit",   commit_cnt,        e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    stall = 1'b0; flush = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;

    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(5'd5, 5'd31);
    @(negedge clk);
    check("post_reset_r1", rdata1, 32'd0);
    check("post_reset_r2", rdata2, 32'd0);

    // Back-to-back writes to R5
    apply(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 5'd5, 5'd0);
    @(negedge clk); check("b2b_ex0", rdata1, 32'h11);
    apply(1'b1, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0, 5'd5, 5'd0);
    @(negedge clk); check("b2b_ex1", rdata1, 32'h22);
    idle(5'd5, 5'd0);
    @(negedge clk); check("b2b_mem", rdata1, 32'h22);
    idle(5'd5, 5'd0);
    @(negedge clk); check("b2b_wb", rdata1, 32'h22);
    idle(5'd5, 5'd0);
    @(negedge clk); check("b2b_arr", rdata1, 32'h22);
    check("b2b_cnt", commit_cnt, 32'd2);

    // R0 guard
    apply(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clk); check("r0_ex", rdata1, 32'd0);
    for (int i = 0; i < 3; i++) idle(5'd0, 5'd0);
    @(negedge clk); check("r0_cnt", commit_cnt, 32'd2);

    // Stall with R7 in MEM
    apply(1'b1, 1'b1, 5'd7, 32'h7, 1'b0, 1'b0, 5'd7, 5'd0);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 5'd0);
    @(negedge clk); check("stall_mem", rdata1, 32'h7);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 5'd0);
    @(negedge clk); check("stall_wb0", 32'(wb_we), 32'd0);
    idle(5'd7, 5'd0);
    @(negedge clk); check("stall_wb1", 32'(wb_we), 32'd0);
    check("stall_hold", rdata1, 32'h7);
    idle(5'd7, 5'd0);
    @(negedge clk); check("stall_drain", 32'(wb_we), 32'd1);
    idle(5'd7, 5'd0);
    @(negedge clk); check("stall_cnt", commit_cnt, 32'd3);

    // Flush kills R9 on EX
    apply(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd9, 5'd0);
    @(negedge clk); check("flush_fwd", rdata1, 32'd0);
    for (int i = 0; i < 3; i++) idle(5'd9, 5'd0);
    @(negedge clk); check("flush_arr", rdata1, 32'd0);
    check("flush_cnt", commit_cnt, 32'd3);

    // Reset with R3 in MEM and R4 in WB
    apply(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 5'd0);
    apply(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd0, 5'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    @(negedge clk);
    check("rst_r3", rdata1, 32'd0);
    check("rst_r4", rdata2, 32'd0);
    check("rst_cnt", commit_cnt, 32'd0);
    idle(5'd7, 5'd5);
    @(negedge clk);
    check("rst_arr7", rdata1, 32'd0);
    check("rst_arr5", rdata2, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 59) != 0,
            $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 3; i++) idle(5'd1, 5'd2);

    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
